apb4_gpio_pro: RTL
==================

APB4_GPIO_PRO -- requirements
Module: apb4_gpio_pro

Interface
REQ-001 SHALL have parameter PIN_NUM, default 32, number of GPIO pins (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGE, default 2, input synchroniser depth (legal range 2..4).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, debounce prescaler width (legal range 1..32).
REQ-004 SHALL have port pclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port preset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have APB4 slave ports: paddr in 32; psel in 1; penable in 1; pwrite in 1; pwdata in 32; prdata out 32; pready out 1; pslverr out 1.
REQ-007 SHALL have pin ports: gpio_in_i in PIN_NUM; gpio_out_o out PIN_NUM; gpio_dir_o out PIN_NUM (1 = output); gpio_iof_o out PIN_NUM; irq_o out 1.

Function
REQ-008 SHALL decode the register index from paddr[5:2]: 0 PADDIR, 1 PADIN(RO), 2 PADOUT, 3 INTEN, 4 INTTYPE0, 5 INTTYPE1, 6 INTSTATUS(W1C), 7 IOFCFG, 8 PADSET(WO), 9 PADCLR(WO), 10 INTBOTH, 11 DBNCEN, 12 DBNCDIV.
REQ-009 SHALL define write access as psel&penable&pwrite and read access as psel&penable&~pwrite; pready SHALL be constant 1 (zero wait states).
REQ-010 SHALL drive pslverr=1 during an access to index 13..15, with no state change; pslverr=0 otherwise.
REQ-011 SHALL drive prdata with the addressed register, zero-extended to 32 bits, only during read access; prdata=0 at all other times, including reads of PADSET, PADCLR and unmapped indices.
REQ-012 SHALL ignore pwdata bits above PIN_NUM-1 (above DIV_WIDTH-1 for DBNCDIV).
REQ-013 SHALL update PADOUT |= pwdata on a PADSET write and PADOUT &= ~pwdata on a PADCLR write, in the same cycle as the access.
REQ-014 SHALL pass gpio_in_i through a SYNC_STAGE-deep flop chain per pin (sync value).
REQ-015 SHALL run the debounce prescaler as a counter 0..DBNCDIV, issuing a one-cycle tick when count==DBNCDIV and then wrapping to 0; DBNCDIV=0 SHALL tick every cycle.
REQ-016 SHALL clear the prescaler count to 0 on any DBNCDIV write.
REQ-017 SHALL, per pin on each tick, shift the sync value into a 3-bit history; the filtered value SHALL take the history value only when all 3 bits are equal, and hold otherwise.
REQ-018 SHALL select, per pin, the filtered value when DBNCEN=1 and the sync value when DBNCEN=0 (pin value); PADIN SHALL read the pin value.
REQ-019 SHALL register the pin value each cycle as prev; rise = pin&~prev; fall = ~pin&prev.
REQ-020 SHALL raise a pin event when INTEN=1 and, by mode: INTBOTH=1 -> rise|fall; else {INTTYPE1,INTTYPE0}: 00 -> level high, 01 -> level low, 10 -> rise, 11 -> fall.
REQ-021 SHALL set the INTSTATUS bit on the clock edge after its pin event and hold it until cleared; bits are independent per pin (sticky, no clear-all).
REQ-022 SHALL clear the INTSTATUS bits written as 1 on an INTSTATUS write; an event on the same bit in the same cycle SHALL win (bit stays 1).
REQ-023 SHALL keep a level-mode INTSTATUS bit re-set every cycle while its level persists; W1C takes effect only once the level is gone.
REQ-024 SHALL leave existing INTSTATUS bits unchanged when INTEN is cleared; no new events are raised for that pin.
REQ-025 SHALL drive irq_o = OR of INTSTATUS, with no extra register stage.
REQ-026 SHALL give an undebounced-edge latency of SYNC_STAGE+1 rising edges from a gpio_in_i change to the INTSTATUS/irq_o assertion.

Reset
REQ-027 SHALL, while preset=1, immediately clear all registers, the sync chain, debounce history, filtered value, prev and the prescaler to 0.
REQ-028 SHALL, while preset=1, drive gpio_out_o=0, gpio_dir_o=0, gpio_iof_o=0, irq_o=0, prdata=0 and pslverr=0.
REQ-029 SHALL abandon a reset that lands mid-debounce or mid-access with no partial update, and resume from the all-zero state.

Verification
REQ-030 SHALL pass: write PADOUT=0x0F, then PADSET=0xF0, then PADCLR=0x03 -> PADOUT reads 0xFC and gpio_out_o=0xFC.
REQ-031 SHALL pass: INTEN[0]=1, INTBOTH[0]=1, toggle pin0 0->1 with SYNC_STAGE=2 -> INTSTATUS=0x1 and irq_o=1 at edge 3; W1C 0x1 -> 0; pin0 1->0 -> sets again.
REQ-032 SHALL pass: level-high mode on pin5 held high, W1C 0x20 -> INTSTATUS[5] still 1; pin5 low then W1C -> 0 and irq_o=0.
REQ-033 SHALL pass: DBNCEN[2]=1, DBNCDIV=3, a 2-cycle glitch on pin2 -> PADIN[2] stays 0; a level held high for at least 12 cycles -> PADIN[2]=1.
REQ-034 SHALL pass: a read of index 14 -> pslverr=1, prdata=0; a write to index 13 -> pslverr=1 and all registers unchanged.
REQ-035 SHALL pass: preset pulse after INTSTATUS=0xFF -> irq_o=0 and all reads return 0 during the reset cycle, before the next clock edge.

Source files
------------

// File: rtl/apb4_gpio_pro.sv
// APB4 GPIO controller: pad direction/output/alternate-function registers,
// synchronised and optionally debounced inputs, per-pin interrupt detection
// with sticky W1C status and a combined interrupt line.
`timescale 1ns/100ps
module apb4_gpio_pro #(
  parameter int PIN_NUM    = 32,
  parameter int SYNC_STAGE = 2,
  parameter int DIV_WIDTH  = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [31:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [PIN_NUM-1:0] gpio_in_i,
  output logic [PIN_NUM-1:0] gpio_out_o,
  output logic [PIN_NUM-1:0] gpio_dir_o,
  output logic [PIN_NUM-1:0] gpio_iof_o,
  output logic               irq_o
);

  localparam logic [3:0] IDX_PADDIR    = 4'd0;
  localparam logic [3:0] IDX_PADIN     = 4'd1;
  localparam logic [3:0] IDX_PADOUT    = 4'd2;
  localparam logic [3:0] IDX_INTEN     = 4'd3;
  localparam logic [3:0] IDX_INTTYPE0  = 4'd4;
  localparam logic [3:0] IDX_INTTYPE1  = 4'd5;
  localparam logic [3:0] IDX_INTSTATUS = 4'd6;
  localparam logic [3:0] IDX_IOFCFG    = 4'd7;
  localparam logic [3:0] IDX_PADSET    = 4'd8;
  localparam logic [3:0] IDX_PADCLR    = 4'd9;
  localparam logic [3:0] IDX_INTBOTH   = 4'd10;
  localparam logic [3:0] IDX_DBNCEN    = 4'd11;
  localparam logic [3:0] IDX_DBNCDIV   = 4'd12;

  logic [3:0]           idx;
  logic                 wr_acc, rd_acc, bad_idx;
  logic [PIN_NUM-1:0]   wdata_p;
  logic [DIV_WIDTH-1:0] wdata_d;
  logic                 unused_bits;

  logic [PIN_NUM-1:0]   paddir, padout, inten, inttype0, inttype1;
  logic [PIN_NUM-1:0]   intstatus, iofcfg, intboth, dbncen;
  logic [DIV_WIDTH-1:0] dbncdiv, div_cnt;
  logic                 tick;

  logic [PIN_NUM-1:0]   sync_q [SYNC_STAGE];
  logic [PIN_NUM-1:0]   sync_val;
  logic [PIN_NUM-1:0]   hist0, hist1, hist2, filt;
  logic [PIN_NUM-1:0]   pin_val, prev, rise, fall, mode_evt, evt;
  logic [31:0]          rd_data;

  assign idx         = paddr[5:2];
  assign wr_acc      = psel & penable & pwrite;
  assign rd_acc      = psel & penable & ~pwrite;
  assign bad_idx     = (idx >= 4'd13);
  assign wdata_p     = pwdata[PIN_NUM-1:0];
  assign wdata_d     = pwdata[DIV_WIDTH-1:0];
  assign unused_bits = ^{paddr[31:6], paddr[1:0], pwdata};

  // input synchroniser chain, one flop per stage per pin
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < SYNC_STAGE; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int i = 1; i < SYNC_STAGE; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGE-1];

  // debounce prescaler: counts 0..DBNCDIV, restarts whenever the divider is rewritten
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                              div_cnt <= '0;
    else if (wr_acc && idx == IDX_DBNCDIV)   div_cnt <= '0;
    else if (tick)                           div_cnt <= '0;
    else                                     div_cnt <= div_cnt + DIV_WIDTH'(1);
  end

  assign tick = (div_cnt == dbncdiv);

  // 3-deep sample history per pin; the filter only follows a unanimous history
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      hist0 <= '0;
      hist1 <= '0;
      hist2 <= '0;
      filt  <= '0;
    end else begin
      if (tick) begin
        hist0 <= sync_val;
        hist1 <= hist0;
        hist2 <= hist1;
      end
      filt <= (filt | (hist0 & hist1 & hist2)) & (hist0 | hist1 | hist2);
    end
  end

  assign pin_val = (dbncen & filt) | (~dbncen & sync_val);

  // previous pin value for edge detection
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) prev <= '0;
    else        prev <= pin_val;
  end

  assign rise     = pin_val & ~prev;
  assign fall     = ~pin_val & prev;
  assign mode_evt = (intboth & (rise | fall)) |
                    (~intboth & ~inttype1 & ~inttype0 & pin_val) |
                    (~intboth & ~inttype1 &  inttype0 & ~pin_val) |
                    (~intboth &  inttype1 & ~inttype0 & rise) |
                    (~intboth &  inttype1 &  inttype0 & fall);
  assign evt      = inten & mode_evt;

  // register file writes and sticky interrupt status (new events beat W1C)
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      paddir    <= '0;
      padout    <= '0;
      inten     <= '0;
      inttype0  <= '0;
      inttype1  <= '0;
      intstatus <= '0;
      iofcfg    <= '0;
      intboth   <= '0;
      dbncen    <= '0;
      dbncdiv   <= '0;
    end else begin
      if (wr_acc) begin
        case (idx)
          IDX_PADDIR:   paddir   <= wdata_p;
          IDX_PADOUT:   padout   <= wdata_p;
          IDX_INTEN:    inten    <= wdata_p;
          IDX_INTTYPE0: inttype0 <= wdata_p;
          IDX_INTTYPE1: inttype1 <= wdata_p;
          IDX_IOFCFG:   iofcfg   <= wdata_p;
          IDX_PADSET:   padout   <= padout | wdata_p;
          IDX_PADCLR:   padout   <= padout & ~wdata_p;
          IDX_INTBOTH:  intboth  <= wdata_p;
          IDX_DBNCEN:   dbncen   <= wdata_p;
          IDX_DBNCDIV:  dbncdiv  <= wdata_d;
          default: ;
        endcase
      end
      if (wr_acc && idx == IDX_INTSTATUS) intstatus <= (intstatus & ~wdata_p) | evt;
      else                                intstatus <= intstatus | evt;
    end
  end

  // read mux, zero-extended; write-only and unmapped indices read as zero
  always_comb begin
    rd_data = '0;
    case (idx)
      IDX_PADDIR:    rd_data[PIN_NUM-1:0]   = paddir;
      IDX_PADIN:     rd_data[PIN_NUM-1:0]   = pin_val;
      IDX_PADOUT:    rd_data[PIN_NUM-1:0]   = padout;
      IDX_INTEN:     rd_data[PIN_NUM-1:0]   = inten;
      IDX_INTTYPE0:  rd_data[PIN_NUM-1:0]   = inttype0;
      IDX_INTTYPE1:  rd_data[PIN_NUM-1:0]   = inttype1;
      IDX_INTSTATUS: rd_data[PIN_NUM-1:0]   = intstatus;
      IDX_IOFCFG:    rd_data[PIN_NUM-1:0]   = iofcfg;
      IDX_INTBOTH:   rd_data[PIN_NUM-1:0]   = intboth;
      IDX_DBNCEN:    rd_data[PIN_NUM-1:0]   = dbncen;
      IDX_DBNCDIV:   rd_data[DIV_WIDTH-1:0] = dbncdiv;
      default:       rd_data                = '0;
    endcase
  end

  assign prdata     = (rd_acc && !preset) ? rd_data : 32'd0;
  assign pslverr    = psel & penable & bad_idx & ~preset;
  assign pready     = 1'b1;
  assign gpio_out_o = padout;
  assign gpio_dir_o = paddir;
  assign gpio_iof_o = iofcfg;
  assign irq_o      = |intstatus;

endmodule
